// File: rtl/gpio_irq_top_if.sv
// -----------------------------------------------------------------------------
// scarv_ccx_memif : simple single-cycle register access bus.
//   req    - access request
//   wen    - 1 = write, 0 = read
//   addr   - byte address
//   wdata  - write data
//   rdata  - read data, valid in the request cycle
//   gnt    - grant
//   error  - access error
// Modports: REQ/master drive the request side, RSP/slave answer it.
// -----------------------------------------------------------------------------
interface scarv_ccx_memif;
  logic        req;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        gnt;
  logic        error;

  modport REQ    (output req, wen, addr, wdata, input  rdata, gnt, error);
  modport RSP    (input  req, wen, addr, wdata, output rdata, gnt, error);
  modport master (output req, wen, addr, wdata, input  rdata, gnt, error);
  modport slave  (input  req, wen, addr, wdata, output rdata, gnt, error);
endinterface

// File: rtl/gpio_irq_top.sv
// -----------------------------------------------------------------------------
// gpio_irq_top : GPIO block with per-pin direction, set/clear output access and
// edge-triggered interrupt pending register.
//   g_clk      - clock
//   g_reset    - synchronous active-high reset
//   g_clk_req  - clock request (always 1)
//   gpio_oe    - per-pin output enable (DIRECTION register)
//   gpio_out   - per-pin output value (OUTPUTS register)
//   gpio_in    - asynchronous pin inputs
//   irq        - level interrupt, high while any PENDING bit is set
//   memif      - register access port (RSP modport)
// Optional feature: define GPIO_DEBOUNCE_EN to add a per-pin debounce filter
// of DEBOUNCE_CYCLES consecutive samples after the synchroniser.
// -----------------------------------------------------------------------------
module gpio_irq_top #(
  parameter int unsigned PERIPH_GPIO_NUM = 16,
  parameter logic [31:0] RESET_OUTPUTS   = 32'h0,
  parameter logic [31:0] RESET_DIRECTION = 32'h0,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                       g_clk,
  input  logic                       g_reset,
  output logic                       g_clk_req,
  output logic [PERIPH_GPIO_NUM-1:0] gpio_oe,
  output logic [PERIPH_GPIO_NUM-1:0] gpio_out,
  input  logic [PERIPH_GPIO_NUM-1:0] gpio_in,
  output logic                       irq,
  scarv_ccx_memif.RSP                memif
);

  localparam int unsigned N = PERIPH_GPIO_NUM;

  typedef enum logic [2:0] {
    REG_INPUTS    = 3'd0,
    REG_OUTPUTS   = 3'd1,
    REG_DIRECTION = 3'd2,
    REG_OUT_SET   = 3'd3,
    REG_OUT_CLR   = 3'd4,
    REG_RISE_EN   = 3'd5,
    REG_FALL_EN   = 3'd6,
    REG_PENDING   = 3'd7
  } reg_e;

  logic [N-1:0] r_outputs, r_direction, r_rise_en, r_fall_en, r_pending;
  logic [N-1:0] r_sync1, r_sync2, r_prev_f;
  logic         r_irq, r_armed;

  logic [N-1:0] w_f, w_wd, w_rd, w_set, w_clr;
  logic [N-1:0] w_outputs_nxt, w_direction_nxt, w_rise_nxt, w_fall_nxt, w_pending_nxt;
  logic [31:0]  w_wdata;
  logic         w_wr, w_rdreq, w_unused_bits;
  reg_e         w_sel;

  assign g_clk_req     = 1'b1;
  assign memif.gnt     = 1'b1;
  assign memif.error   = 1'b0;
  assign gpio_oe       = r_direction;
  assign gpio_out      = r_outputs;
  assign irq           = r_irq;

  assign w_wr          = memif.req &  memif.wen;
  assign w_rdreq       = memif.req & ~memif.wen;
  assign w_sel         = reg_e'(memif.addr[4:2]);
  assign w_wdata       = memif.wdata;
  assign w_wd          = w_wdata[N-1:0];
  assign w_unused_bits = ^{memif.addr[31:5], memif.addr[1:0], w_wdata};

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  // f only follows the synchronised value after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  logic [N-1:0] r_f;
  logic [7:0]   r_cnt [N];

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_f <= '0;
      for (int unsigned i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (r_sync2[i] != r_f[i]) begin
          if (r_cnt[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
            r_f[i]   <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 8'd1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_f = r_f;
`else
  assign w_f = r_sync2;
`endif

  // r_armed gates edge detection for the first cycle after reset release.
  assign w_set = {N{r_armed}} & ~r_direction &
                 (((w_f & ~r_prev_f) & r_rise_en) | ((~w_f & r_prev_f) & r_fall_en));

  always_comb begin
    w_outputs_nxt   = r_outputs;
    w_direction_nxt = r_direction;
    w_rise_nxt      = r_rise_en;
    w_fall_nxt      = r_fall_en;
    w_clr           = '0;
    if (w_wr) begin
      case (w_sel)
        REG_OUTPUTS:   w_outputs_nxt = w_wd & r_direction;
        REG_DIRECTION: begin
          w_direction_nxt = w_wd;
          w_outputs_nxt   = r_outputs & w_wd;
        end
        REG_OUT_SET:   w_outputs_nxt = r_outputs | (w_wd & r_direction);
        REG_OUT_CLR:   w_outputs_nxt = r_outputs & ~w_wd;
        REG_RISE_EN:   w_rise_nxt    = w_wd;
        REG_FALL_EN:   w_fall_nxt    = w_wd;
        REG_PENDING:   w_clr         = w_wd;
        REG_INPUTS:    ;
      endcase
    end
    // A new edge beats a simultaneous write-1-to-clear.
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      r_outputs   <= RESET_OUTPUTS[N-1:0] & RESET_DIRECTION[N-1:0];
      r_direction <= RESET_DIRECTION[N-1:0];
      r_rise_en   <= '0;
      r_fall_en   <= '0;
      r_pending   <= '0;
      r_prev_f    <= '0;
      r_irq       <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_outputs   <= w_outputs_nxt;
      r_direction <= w_direction_nxt;
      r_rise_en   <= w_rise_nxt;
      r_fall_en   <= w_fall_nxt;
      r_pending   <= w_pending_nxt;
      r_prev_f    <= w_f;
      r_irq       <= |w_pending_nxt;
      r_armed     <= 1'b1;
    end
  end

  always_comb begin
    w_rd = '0;
    if (w_rdreq) begin
      case (w_sel)
        REG_INPUTS:    w_rd = w_f & ~r_direction;
        REG_OUTPUTS:   w_rd = r_outputs;
        REG_DIRECTION: w_rd = r_direction;
        REG_RISE_EN:   w_rd = r_rise_en;
        REG_FALL_EN:   w_rd = r_fall_en;
        REG_PENDING:   w_rd = r_pending;
        REG_OUT_SET,
        REG_OUT_CLR:   w_rd = '0;
      endcase
    end
  end

  assign memif.rdata = 32'(w_rd);

endmodule

// File: doc/gpio_irq_top.md
GPIO_IRQ_TOP -- requirements
Module: gpio_irq_top

Interface
REQ-001 The block SHALL take parameter PERIPH_GPIO_NUM, default 16, meaning the number of GPIO pins, legal range 1..32.
REQ-002 The block SHALL take parameter RESET_OUTPUTS, default 0, meaning the reset value of the OUTPUTS register.
REQ-003 The block SHALL take parameter RESET_DIRECTION, default 0, meaning the reset value of the DIRECTION register.
REQ-004 The block SHALL take parameter DEBOUNCE_CYCLES, default 4, meaning the number of stable samples the debounce filter requires, legal range 2..255.
REQ-005 The block SHALL have port g_clk, input, width 1: the single clock; one clock, reset synchronous and active-high.
REQ-006 The block SHALL have port g_reset, input, width 1: synchronous active-high reset.
REQ-007 The block SHALL have port g_clk_req, output, width 1: clock request, held at 1.
REQ-008 The block SHALL have port gpio_oe, output, width PERIPH_GPIO_NUM: per-pin direction, 1 = output.
REQ-009 The block SHALL have port gpio_out, output, width PERIPH_GPIO_NUM: per-pin output value.
REQ-010 The block SHALL have port gpio_in, input, width PERIPH_GPIO_NUM: asynchronous pin inputs.
REQ-011 The block SHALL have port irq, output, width 1: level interrupt, high while any pending bit is set.
REQ-012 The block SHALL have port memif, scarv_ccx_memif.RSP modport: register access (req, wen, addr, wdata, rdata, gnt, error).

Function
REQ-013 memif.gnt SHALL be constant 1 and memif.error constant 0; a write occurs on req&wen, a read on req&!wen.
REQ-014 Register decode SHALL use addr[4:2]: 0 INPUTS (RO), 1 OUTPUTS (RW), 2 DIRECTION (RW), 3 OUT_SET (WO), 4 OUT_CLR (WO), 5 RISE_EN (RW), 6 FALL_EN (RW), 7 PENDING (RW1C).
REQ-015 rdata SHALL be combinational in the request cycle; bits above PERIPH_GPIO_NUM-1, WO registers, and rdata when req=0 SHALL read 0.
REQ-016 gpio_in SHALL pass through a 2-flop synchroniser; the filtered value f is INPUTS = f & ~DIRECTION.
REQ-017 A DIRECTION write SHALL also set OUTPUTS <= OUTPUTS & wdata in the same cycle.
REQ-018 An OUTPUTS write SHALL store wdata & DIRECTION; OUT_SET SHALL give OUTPUTS |= wdata & DIRECTION; OUT_CLR SHALL give OUTPUTS &= ~wdata.
REQ-019 gpio_oe SHALL equal DIRECTION and gpio_out SHALL equal OUTPUTS, both direct register outputs.
REQ-020 A rising edge SHALL be f=1 with previous f=0, and a falling edge f=0 with previous f=1; edges SHALL be evaluated per pin every cycle.
REQ-021 A PENDING bit SHALL set on an edge whose RISE_EN/FALL_EN bit is 1 and whose DIRECTION bit is 0.
REQ-022 A PENDING write SHALL clear the bits written 1; when set and clear coincide on a bit, set SHALL win.
REQ-023 irq SHALL be registered as OR of PENDING; a gpio_in step at edge t SHALL reach INPUTS after edge t+2 and PENDING/irq after edge t+3 (debounce disabled).
REQ-024 Clearing an enable SHALL NOT clear an already-set PENDING bit.

Reset
REQ-025 While g_reset=1 at a g_clk edge: OUTPUTS=RESET_OUTPUTS&RESET_DIRECTION, DIRECTION=RESET_DIRECTION, RISE_EN=FALL_EN=PENDING=0, synchroniser/previous-f/debounce state=0, irq=0.
REQ-026 Edge detection SHALL be suppressed in the first cycle after reset deassertion, so no pending bit sets from reset state.
REQ-027 Reset asserted mid-transaction SHALL take priority over any write in the same cycle.

Configuration
REQ-028 With GPIO_DEBOUNCE_EN defined, each pin SHALL have a counter: f updates to the synchronised value only after it has differed from f for DEBOUNCE_CYCLES consecutive cycles, and any return to equality resets that pin's counter to 0.
REQ-029 Without GPIO_DEBOUNCE_EN, f SHALL equal the synchroniser output, and DEBOUNCE_CYCLES SHALL be ignored with no counter logic instantiated.

Verification
REQ-030 Reset, then read all 8 addresses -> INPUTS reflects pins, OUTPUTS=0, DIRECTION=0, others 0, irq=0.
REQ-031 DIRECTION=0x00FF, OUTPUTS=0xFFFF -> OUTPUTS reads 0x00FF and gpio_out=0x00FF; then DIRECTION=0x000F -> OUTPUTS=0x000F.
REQ-032 OUT_SET 0x0030 then OUT_CLR 0x0001 with DIRECTION=0x00FF, OUTPUTS=0 -> OUTPUTS=0x0030, then 0x0030 unchanged; OUT_CLR 0x0010 -> 0x0020.
REQ-033 RISE_EN=0x1, gpio_in[0] 0->1 at edge t -> PENDING=0x1 and irq=1 after edge t+3; write PENDING=0x1 -> irq=0 the next cycle.
REQ-034 FALL_EN=0x2, pin 1 falls in the same cycle as a PENDING write of 0x2 -> PENDING[1] remains 1.
REQ-035 With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES=4: a 3-cycle glitch on pin 0 -> no INPUTS change and no pending; a 4-cycle stable high -> INPUTS[0]=1, PENDING[0]=1 if RISE_EN[0].
